// File: rtl/pc_sequencer.sv
// Program-counter sequencer with branch redirect and a circular return-address stack.
// The stack keeps a write pointer to the next free slot, so a push while full overwrites the oldest entry.
module pc_sequencer #(
   parameter int                ADDR_W    = 32,
   parameter int                INC       = 4,
   parameter int                RAS_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              HOLD,
   input  logic              BRANCH,
   input  logic              CALL,
   input  logic              RET,
   input  logic [ADDR_W-1:0] BRANCH_TARGET,
   output logic [ADDR_W-1:0] PC,
   output logic [ADDR_W-1:0] PC_NEXT,
   output logic              RAS_EMPTY,
   output logic              RAS_FULL,
   output logic              RAS_ERR
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(INC - 1));
   localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(RAS_DEPTH);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d, top_idx;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              push;
   logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
   logic [ADDR_W-1:0] target_aligned;

   assign PC_NEXT        = pc_q + ADDR_W'(INC);
   assign PC             = pc_q;
   assign RAS_ERR        = err_q;
   assign RAS_EMPTY      = (cnt_q == '0);
   assign RAS_FULL       = (cnt_q == CNT_MAX);
   assign top_idx        = ptr_q - PTR_W'(1);
   assign target_aligned = BRANCH_TARGET & ALIGN_MASK;

   always_comb begin
      pc_d  = pc_q;
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      err_d = 1'b0;
      push  = 1'b0;
      if (HOLD) begin
         pc_d = pc_q;
      end else if (CALL && RET) begin
         pc_d  = PC_NEXT;
         err_d = 1'b1;
      end else if (RET) begin
         if (cnt_q != '0) begin
            pc_d  = ras_q[top_idx];
            ptr_d = top_idx;
            cnt_d = cnt_q - CNT_W'(1);
         end else begin
            pc_d  = PC_NEXT;
            err_d = 1'b1;
         end
      end else if (CALL) begin
         pc_d  = target_aligned;
         push  = 1'b1;
         ptr_d = ptr_q + PTR_W'(1);
         // Overflow silently recycles the oldest slot; depth stays saturated.
         if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      end else if (BRANCH) begin
         pc_d = target_aligned;
      end else begin
         pc_d = PC_NEXT;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         pc_q  <= RESET_VEC;
         ptr_q <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   // Entry contents are never visible before being written, so they need no reset.
   always_ff @(posedge CLK) begin
      if (push) ras_q[ptr_q] <= PC_NEXT;
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: vector table for the sequencing/stack rules,
// hand-written sequences for asynchronous reset behaviour.
module tb_pc_sequencer;

   logic        clk_sys = 1'b0;
   logic        rst_b;
   logic        hold, branch, call, ret;
   logic [31:0] target;
   logic [31:0] pc, pc_next;
   logic        ras_empty, ras_full, ras_err;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic        hold, branch, call, ret;
      logic [31:0] tgt;
      logic [31:0] pc;
      logic        empty, full, err;
   } vec_t;

   vec_t vecs[$];

   pc_sequencer dut (
      .CLK           (clk_sys),
      .RESET         (rst_b),
      .HOLD          (hold),
      .BRANCH        (branch),
      .CALL          (call),
      .RET           (ret),
      .BRANCH_TARGET (target),
      .PC            (pc),
      .PC_NEXT       (pc_next),
      .RAS_EMPTY     (ras_empty),
      .RAS_FULL      (ras_full),
      .RAS_ERR       (ras_err)
   );

   always #5 clk_sys = ~clk_sys;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(logic h, logic b, logic c, logic r, logic [31:0] t,
                               logic [31:0] p, logic e, logic f, logic x);
      vec_t v;
      v.hold = h; v.branch = b; v.call = c; v.ret = r; v.tgt = t;
      v.pc = p; v.empty = e; v.full = f; v.err = x;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic h, input logic b, input logic c, input logic r,
                        input logic [31:0] t);
      hold = h; branch = b; call = c; ret = r; target = t;
   endtask

   task automatic check_all(input string tag, input logic [31:0] e_pc, input logic e_empty,
                            input logic e_full, input logic e_err);
      logic [31:0] e_next;
      e_next = e_pc + 32'd4;
      chk({tag, " pc"},      pc,               e_pc);
      chk({tag, " pc_next"}, pc_next,          e_next);
      chk({tag, " empty"},   {31'd0, ras_empty}, {31'd0, e_empty});
      chk({tag, " full"},    {31'd0, ras_full},  {31'd0, e_full});
      chk({tag, " err"},     {31'd0, ras_err},   {31'd0, e_err});
   endtask

   initial begin
      //                 hold br call ret target         pc            emp full err
      vecs.push_back(mk(0, 0, 0, 0, 32'h0,          32'h0000_0004, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 32'h0,          32'h0000_0008, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 32'h0,          32'h0000_000C, 1, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 32'h10,         32'h0000_0010, 1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 32'h100,        32'h0000_0100, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 32'h200,        32'h0000_0200, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 32'h0,          32'h0000_0104, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 32'h0,          32'h0000_0014, 1, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 32'h103,        32'h0000_0100, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 32'h0,          32'h0000_0104, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 32'h0,          32'h0000_0108, 1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 32'h1000,       32'h0000_1000, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 32'h2000,       32'h0000_2000, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 32'h3000,       32'h0000_3000, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 32'h4000,       32'h0000_4000, 0, 1, 0));
      vecs.push_back(mk(0, 0, 1, 0, 32'h5000,       32'h0000_5000, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 1, 32'h0,          32'h0000_4004, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 32'h0,          32'h0000_3004, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 32'h0,          32'h0000_2004, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 32'h0,          32'h0000_1004, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 32'h0,          32'h0000_1008, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 32'h0,          32'h0000_100C, 1, 0, 0));
      vecs.push_back(mk(0, 1, 1, 0, 32'h300,        32'h0000_0300, 0, 0, 0));
      vecs.push_back(mk(1, 0, 1, 0, 32'h300,        32'h0000_0300, 0, 0, 0));
      vecs.push_back(mk(1, 0, 1, 0, 32'h300,        32'h0000_0300, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 1, 32'h700,        32'h0000_0304, 0, 0, 1));
      vecs.push_back(mk(1, 0, 0, 1, 32'h0,          32'h0000_0304, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 1, 32'h900,        32'h0000_1010, 1, 0, 0));
      vecs.push_back(mk(1, 0, 0, 1, 32'h0,          32'h0000_1010, 1, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 32'h0,          32'h0000_0000, 1, 0, 0));

      drive(0, 0, 0, 0, 32'h0);
      rst_b = 1'b0;
      #1;
      check_all("reset", 32'h0, 1'b1, 1'b0, 1'b0);
      repeat (2) @(posedge clk_sys);
      @(negedge clk_sys);
      rst_b = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].hold, vecs[i].branch, vecs[i].call, vecs[i].ret, vecs[i].tgt);
         @(posedge clk_sys);
         #1;
         check_all($sformatf("v%0d", i), vecs[i].pc, vecs[i].empty, vecs[i].full, vecs[i].err);
      end

      // Build a stack of three, then reset mid-cycle with a held CALL pending.
      drive(0, 0, 1, 0, 32'h40); @(posedge clk_sys); #1;
      drive(0, 0, 1, 0, 32'h80); @(posedge clk_sys); #1;
      drive(0, 0, 1, 0, 32'hC0); @(posedge clk_sys); #1;
      check_all("three_calls", 32'hC0, 1'b0, 1'b0, 1'b0);
      drive(1, 0, 1, 0, 32'h300);
      #2;
      rst_b = 1'b0;
      #1;
      check_all("async_rst", 32'h0, 1'b1, 1'b0, 1'b0);
      @(posedge clk_sys); #1;
      check_all("rst_held", 32'h0, 1'b1, 1'b0, 1'b0);
      @(negedge clk_sys);
      rst_b = 1'b1;
      drive(0, 0, 0, 1, 32'h0);
      @(posedge clk_sys); #1;
      check_all("post_rst_ret", 32'h4, 1'b1, 1'b0, 1'b1);

      // Reset while the error pulse is high clears it immediately.
      drive(0, 0, 0, 0, 32'h0);
      #2;
      rst_b = 1'b0;
      #1;
      check_all("rst_clears_err", 32'h0, 1'b1, 1'b0, 1'b0);
      @(negedge clk_sys);
      rst_b = 1'b1;
      @(posedge clk_sys); #1;
      check_all("first_edge", 32'h4, 1'b1, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_W, default 32, width of all address ports and internal address registers.
REQ-002 Parameter INC, default 4, sequential increment in bytes; SHALL be a power of two, 1..16.
REQ-003 Parameter RAS_DEPTH, default 4, return-address-stack entries; SHALL be a power of two, 2..16.
REQ-004 Parameter RESET_VEC, default 0, PC value loaded on reset.
REQ-005 CLK  input  1  single clock; all state updates on rising edge.
REQ-006 RESET  input  1  asynchronous, active-low reset.
REQ-007 HOLD  input  1  stall; when 1, no state changes on the clock edge.
REQ-008 BRANCH  input  1  taken branch or jump; redirect to BRANCH_TARGET.
REQ-009 CALL  input  1  call; redirect to BRANCH_TARGET and push PC+INC.
REQ-010 RET  input  1  return; pop the stack and redirect to the popped address.
REQ-011 BRANCH_TARGET  input  ADDR_W  redirect address for BRANCH/CALL.
REQ-012 PC  output  ADDR_W  registered address of the current instruction.
REQ-013 PC_NEXT  output  ADDR_W  combinational PC+INC, modulo 2^ADDR_W.
REQ-014 RAS_EMPTY  output  1  stack holds 0 entries.
REQ-015 RAS_FULL  output  1  stack holds RAS_DEPTH entries.
REQ-016 RAS_ERR  output  1  registered one-cycle pulse flagging an illegal stack operation.

Function
REQ-017 Per-edge priority when HOLD=0: (CALL&RET) > RET > CALL > BRANCH > sequential.
REQ-018 Sequential: PC <= PC_NEXT; wrap from 2^ADDR_W-INC to 0 SHALL occur silently.
REQ-019 BRANCH alone: PC <= BRANCH_TARGET with low log2(INC) bits forced to 0.
REQ-020 CALL alone: PC <= aligned BRANCH_TARGET; push PC_NEXT at the top; count+1.
REQ-021 CALL when full: overwrite the oldest entry circularly; count stays RAS_DEPTH; RAS_ERR=0; RAS_FULL stays 1.
REQ-022 RET with count>0: PC <= top entry; count-1; the entry below becomes top.
REQ-023 RET with count=0: PC <= PC_NEXT; count stays 0; RAS_ERR pulses 1 for one cycle.
REQ-024 CALL and RET both 1: PC <= PC_NEXT; stack unchanged; RAS_ERR pulses 1; BRANCH ignored.
REQ-025 BRANCH asserted with CALL or RET: BRANCH ignored; CALL or RET rule applies.
REQ-026 HOLD=1: PC, stack pointer, count and entries hold; RAS_ERR <= 0; all other inputs ignored.
REQ-027 RAS_EMPTY and RAS_FULL SHALL be decoded from the registered count, valid in the same cycle the count changes.
REQ-028 Stack storage: RAS_DEPTH x ADDR_W registers, a log2(RAS_DEPTH)-bit top pointer, and a 0..RAS_DEPTH count.
REQ-029 The redirect-to-PC latency SHALL be exactly one edge; PC_NEXT follows PC combinationally with no register.

Reset
REQ-030 RESET=0 SHALL immediately, without waiting for CLK, set PC=RESET_VEC, count=0, top pointer=0, RAS_ERR=0.
REQ-031 During reset RAS_EMPTY=1, RAS_FULL=0; stack entry contents are don't-care and never observable.
REQ-032 Reset asserted mid-operation, including during HOLD or a pending CALL/RET, SHALL discard all in-flight state.
REQ-033 The first rising edge with RESET=1 SHALL apply normal REQ-017 rules from PC=RESET_VEC.

Verification
REQ-034 Reset release, 3 idle edges, defaults -> PC 0,4,8,12; PC_NEXT = PC+4 each cycle; RAS_EMPTY=1.
REQ-035 Nesting calls at PC=0x10 CALL 0x100, then at 0x100 CALL 0x200, then RET, RET -> PC 0x100, 0x200, 0x104, 0x14; RAS_EMPTY=1 at the end.
REQ-036 Overflow and underflow: 5 CALLs with depth 4 then 5 RETs -> RAS_FULL=1 after the 4th CALL; RETs return addresses from CALLs 5,4,3,2; the 5th RET gives PC_NEXT with RAS_ERR=1 for one cycle.
REQ-037 Hold and priority: HOLD=1 with CALL 0x300 for 2 edges -> PC and count unchanged, RAS_ERR=0; CALL and RET with BRANCH on one edge -> PC=PC+4, RAS_ERR=1.
REQ-038 Reset and wrap: PC at 0xFFFFFFFC sequential -> PC 0x0; async RESET low mid-cycle with count=3 -> PC=RESET_VEC before the next edge, RAS_EMPTY=1; BRANCH 0x103 -> PC 0x100.
